// File: rtl/gf_poly_mult_pkg.sv
// Shared AES arithmetic definitions: field width, reduction polynomial, and
// the multiplier control states.
package gf_poly_mult_pkg;

    localparam int unsigned AES_WIDTH = 8;
    localparam logic [AES_WIDTH:0] AES_POLY = 9'h11B;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        REDUCE = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/gf_xor_step.sv
// Conditional shift-and-XOR of an accumulator by an operand placed at a bit
// position. Shared by the multiply phase (operand a) and the reduction phase
// (operand POLY).
module gf_xor_step #(
    parameter int unsigned ACC_W = 15,
    parameter int unsigned OP_W  = 8,
    parameter int unsigned POS_W = 3
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [OP_W-1:0]  operand,
    input  logic [POS_W-1:0] pos,
    input  logic             en,
    output logic [ACC_W-1:0] result_c
);

    // XOR the shifted operand into the accumulator when enabled
    always_comb begin
        result_c = acc;
        if (en) begin
            result_c = acc ^ (ACC_W'(operand) << pos);
        end
    end

endmodule

// File: rtl/gf_poly_mult.sv
// Sequential carry-less GF(2)[x] multiplier, one shift-XOR step per clock.
// Build option GF_MUL_REDUCE_EN: adds a REDUCE phase that folds the product
// modulo POLY, making the block a standalone GF(2^WIDTH) multiplier.
module gf_poly_mult
    import gf_poly_mult_pkg::*;
#(
    parameter int unsigned       WIDTH = AES_WIDTH,
    parameter logic [WIDTH:0]    POLY  = AES_POLY
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-2:0]   product,
    output logic                 busy
);

    localparam int unsigned PROD_W = 2 * WIDTH - 1;
    localparam int unsigned CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t              state, state_next;
    logic [WIDTH-1:0]    a_r, a_next;
    logic [WIDTH-1:0]    b_r, b_next;
    logic [PROD_W-1:0]   acc, acc_next;
    logic [CNT_W-1:0]    cnt, cnt_next;
    logic [PROD_W-1:0]   run_acc_c;

    // Multiply step: add a_r << cnt when the current multiplier bit is set
    gf_xor_step #(
        .ACC_W (PROD_W),
        .OP_W  (WIDTH),
        .POS_W (CNT_W)
    ) u_run_step (
        .acc      (acc),
        .operand  (a_r),
        .pos      (cnt),
        .en       (b_r[cnt]),
        .result_c (run_acc_c)
    );

`ifdef GF_MUL_REDUCE_EN
    localparam int unsigned K_W = $clog2(PROD_W);

    logic [K_W-1:0]      k, k_next;
    logic [K_W-1:0]      red_pos;
    logic [PROD_W-1:0]   red_acc_c;

    assign red_pos = k - K_W'(WIDTH);

    // Reduction step: cancel bit k by adding POLY << (k - WIDTH)
    gf_xor_step #(
        .ACC_W (PROD_W),
        .OP_W  (WIDTH + 1),
        .POS_W (K_W)
    ) u_red_step (
        .acc      (acc),
        .operand  (POLY),
        .pos      (red_pos),
        .en       (acc[k]),
        .result_c (red_acc_c)
    );
`else
    logic unused_poly;
    assign unused_poly = ^POLY;
`endif

    assign product = acc;

    // State, datapath and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_r       <= '0;
            b_r       <= '0;
            acc       <= '0;
            cnt       <= '0;
`ifdef GF_MUL_REDUCE_EN
            k         <= '0;
`endif
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            a_r       <= a_next;
            b_r       <= b_next;
            acc       <= acc_next;
            cnt       <= cnt_next;
`ifdef GF_MUL_REDUCE_EN
            k         <= k_next;
`endif
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
            busy      <= (state_next != IDLE);
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_next = state;
        a_next     = a_r;
        b_next     = b_r;
        acc_next   = acc;
        cnt_next   = cnt;
`ifdef GF_MUL_REDUCE_EN
        k_next     = k;
`endif
        case (state)
            IDLE: begin
                if (in_valid) begin
                    a_next     = a;
                    b_next     = b;
                    acc_next   = '0;
                    cnt_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                acc_next = run_acc_c;
                cnt_next = cnt + CNT_W'(1);
                if (cnt == CNT_W'(WIDTH - 1)) begin
`ifdef GF_MUL_REDUCE_EN
                    k_next     = K_W'(PROD_W - 1);
                    state_next = REDUCE;
`else
                    state_next = DONE;
`endif
                end
            end
`ifdef GF_MUL_REDUCE_EN
            REDUCE: begin
                acc_next = red_acc_c;
                k_next   = k - K_W'(1);
                if (k == K_W'(WIDTH)) begin
                    state_next = DONE;
                end
            end
`endif
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_gf_poly_mult.sv
// Directed bench for gf_poly_mult (WIDTH=8) with a product scoreboard.
// Expected values follow the GF_MUL_REDUCE_EN build setting.
module tb_gf_poly_mult;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] product;
    logic        busy;

    int errors = 0;
    int checks = 0;
    logic [14:0] exp_q[$];
    logic [14:0] held;

`ifdef GF_MUL_REDUCE_EN
    localparam int LAT = 15;
    localparam logic [14:0] E_57_83 = 15'h00C1;
    localparam logic [14:0] E_57_13 = 15'h00FE;
    localparam logic [14:0] E_FF_FF = 15'h0013;
`else
    localparam int LAT = 8;
    localparam logic [14:0] E_57_83 = 15'h2B79;
    localparam logic [14:0] E_57_13 = 15'h0589;
    localparam logic [14:0] E_FF_FF = 15'h5555;
`endif

    gf_poly_mult dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present operands at a falling edge; returns at the falling edge after the accepting edge
    task automatic drive(input logic [7:0] ta, input logic [7:0] tb, input logic [14:0] expv);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        a = ta;
        b = tb;
        in_valid = 1'b1;
        exp_q.push_back(expv);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid, checking busy, latency and product
    task automatic collect(input string tag);
        int j = 0;
        logic [14:0] e;
        while (!out_valid && j < 100) begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            @(negedge clk);
            j++;
        end
        check({tag, "_latency"}, 32'(j), 32'(LAT));
        check({tag, "_queue"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_product"}, 32'(product), 32'(e));
        end
    endtask

    // Full transaction with out_ready high: single-cycle out_valid, then IDLE
    task automatic txn(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                       input logic [14:0] expv);
        drive(ta, tb, expv);
        collect(tag);
        @(negedge clk);
        check({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        txn("m57_83", 8'h57, 8'h83, E_57_83);
        txn("m57_13", 8'h57, 8'h13, E_57_13);
        txn("mFF_FF", 8'hFF, 8'hFF, E_FF_FF);
        txn("m00_A5", 8'h00, 8'hA5, 15'h0000);

        // Back-pressure: hold in DONE, ignore in_valid, then overlap in_valid with out_ready
        out_ready = 1'b0;
        drive(8'h57, 8'h13, E_57_13);
        collect("stall");
        held = product;
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            a = 8'h11;
            b = 8'h22;
            @(negedge clk);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_product", 32'(product), 32'(held));
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        a = 8'h0F;
        b = 8'h0F;
        in_valid = 1'b1;
        out_ready = 1'b1;
        exp_q.push_back(15'h0055);
        @(negedge clk);
        check("release_out_valid", 32'(out_valid), 32'd0);
        check("release_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("next_accept_busy", 32'(busy), 32'd1);
        check("next_accept_in_ready", 32'(in_ready), 32'd0);
        collect("m0F_0F");
        @(negedge clk);
        check("m0F_0F_ov_drop", 32'(out_valid), 32'd0);

        // Asynchronous reset while RUN is at cnt=3
        drive(8'h57, 8'h83, E_57_83);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_product", 32'(product), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        txn("m02_03", 8'h02, 8'h03, 15'h0006);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gf_poly_mult.md
# gf_poly_mult

Sequential carry-less GF(2)[x] polynomial multiplier for the AES SubBytes datapath. It sits directly upstream of the modulo-0x11B polynomial reducer. It accepts two WIDTH-bit operands over a valid/ready handshake, forms their 2·WIDTH-1-bit unreduced product with one shift-and-XOR step per clock, and presents that product to the reducer. An optional in-block reduction phase lets the block stand alone as a full GF(2^8) multiplier.

## Interface
- WIDTH, 8: operand width in bits; the product is 2·WIDTH-1 bits.
- POLY, 9'h11B: reduction polynomial, WIDTH+1 bits. Used only when reduction is compiled in.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  operands a/b are valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier; scanned LSB first.
- out_valid  output  1  product is valid.
- out_ready  input  1  downstream accepts the product.
- product  output  2·WIDTH-1  result; bits [2·WIDTH-2:WIDTH] are zero when reduced.
- busy  output  1  high in any state other than IDLE.

## Operation
- States: IDLE, RUN, REDUCE (present only with the macro), DONE.
- IDLE: in_ready=1. When in_valid && in_ready on an edge:
  - capture a into a_r and b into b_r;
  - clear acc;
  - set cnt=0;
  - go to RUN.
- RUN, each edge:
  - if b_r[cnt], then acc ^= a_r << cnt;
  - cnt++.
  - After the step with cnt=WIDTH-1, go to REDUCE if compiled in, otherwise DONE.
- REDUCE: k runs from 2·WIDTH-2 down to WIDTH, one bit per edge.
  - If acc[k], then acc ^= POLY << (k-WIDTH).
  - After k=WIDTH, go to DONE.
- DONE: out_valid=1 and product=acc, held stable until out_valid && out_ready. On that handshake, return to IDLE.
- Arithmetic rules:
  - all additions are XOR;
  - no carries;
  - acc is exactly 2·WIDTH-1 bits wide, and shifts never overflow it.
- in_valid is ignored outside IDLE. No operand buffering; one transaction in flight.
- A zero operand still takes the full latency (fixed-latency block).

## Timing
- Reset values: state=IDLE, acc=0, cnt=0. Outputs after reset: in_ready=1, out_valid=0, busy=0, product=0.
- Reset mid-operation aborts immediately: outputs return to the reset values asynchronously, and the partial result is discarded.
- Latency from the accepting edge N to out_valid high:
  - WIDTH edges without reduction (edge N+8 for WIDTH=8);
  - 2·WIDTH-1 edges with reduction (edge N+15).
- With out_ready held high:
  - out_valid is high for exactly one cycle;
  - in_ready is high on the following cycle.
- Throughput is one product per WIDTH+2 cycles, or 2·WIDTH+1 cycles with reduction.
- Simultaneous in_valid and out_ready in DONE: the product completes; the new operands are not accepted until IDLE.
- product is registered with no combinational path from inputs.
- out_valid is a function of state only.

## Configuration
- GF_MUL_REDUCE_EN defined:
  - the REDUCE state and POLY logic are compiled in;
  - product is the GF(2^8) field product;
  - bits above WIDTH-1 are always zero.
- Undefined:
  - REDUCE is absent;
  - product is the raw carry-less product, and the downstream reducer finishes the job;
  - POLY is unused.

## Structure
- Shared AES package holds:
  - the state enum (IDLE/RUN/REDUCE/DONE);
  - AES_POLY = 9'h11B;
  - AES_WIDTH = 8.
- The reducer and this block both import AES_POLY.
- Natural sub-module: gf_xor_step, a combinational conditional shift-XOR of acc by an operand at a given bit position. It is used for both RUN (operand a_r) and REDUCE (operand POLY).
- Control FSM and counters stay in the top module.

## Test plan
- a=0x57, b=0x83:
  - without macro, product=0x2B79 on edge N+8;
  - with macro, product=0x00C1 on edge N+15.
- a=0x57, b=0x13 -> product=0x0589 without the macro; 0x00FE with it.
- a=0xFF, b=0xFF -> product=0x5555 without the macro; 0x0013 with it.
- a=0x00, b=0xA5 -> product=0 with full latency, and busy high throughout.
- out_ready held low 5 cycles in DONE:
  - product and out_valid stay stable;
  - in_ready stays 0;
  - in_valid pulses are ignored;
  - after out_ready rises, the next transaction is accepted one cycle later.
- rst_n asserted at RUN cnt=3:
  - outputs return to reset values immediately;
  - after release, a=0x02, b=0x03 gives product=0x0006.
